// File: rtl/timer_dev_if.sv
// Device-bus port bundle between the address-decode bridge and the timer.
// The bridge is the master; the timer is the slave.
interface timer_dev_if;
   logic [1:0]  dev_addr;
   logic        we;
   logic [31:0] dev_writeData;
   logic [31:0] timer_rd;
   logic        irq;

   modport master (
      output dev_addr,
      output we,
      output dev_writeData,
      input  timer_rd,
      input  irq
   );

   modport slave (
      input  dev_addr,
      input  we,
      input  dev_writeData,
      output timer_rd,
      output irq
   );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counting timer with one-shot / auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, read-only COUNT; irq from a flop.
module timer_dev (
   input  logic        clk,
   input  logic        rst_n,
   timer_dev_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  ctrl_r;
   logic [3:0]  ctrl_s;
   logic [3:0]  ctrl_fsm_s;
   logic [31:0] preset_r;
   logic [31:0] preset_s;
   logic [31:0] count_r;
   logic [31:0] count_s;
   logic        irq_r;
   logic        irq_s;
   logic [31:0] rd_s;
   logic        en_s;
   logic        auto_s;
   logic        wr_ctrl_s;
   logic        wr_preset_s;

   assign en_s        = ctrl_r[0];
   assign auto_s      = (ctrl_r[2:1] == 2'b01);
   assign wr_ctrl_s   = bus.we && (bus.dev_addr == 2'd0);
   assign wr_preset_s = bus.we && (bus.dev_addr == 2'd1);

   // Next-state, counter and register update logic
   always_comb begin
      state_s    = state_r;
      ctrl_fsm_s = ctrl_r;
      count_s    = count_r;
      case (state_r)
         ST_IDLE: begin
            if (en_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_s = preset_r;
            state_s = ST_CNT;
         end
         ST_CNT: begin
            // Zero test comes before the decrement so COUNT never wraps.
            if (!en_s) begin
               state_s = ST_IDLE;
            end else if (count_r != 32'd0) begin
               count_s = count_r - 32'd1;
            end else begin
               state_s = ST_INT;
               if (!auto_s) begin
                  ctrl_fsm_s[0] = 1'b0;
               end else begin
                  ctrl_fsm_s[0] = ctrl_r[0];
               end
            end
         end
         ST_INT: begin
            if (auto_s) begin
               state_s = en_s ? ST_LOAD : ST_IDLE;
            end else if (wr_ctrl_s || wr_preset_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_INT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // A CPU write to CTRL overrides the EN auto-clear on the same edge.
      ctrl_s   = wr_ctrl_s   ? bus.dev_writeData[3:0] : ctrl_fsm_s;
      preset_s = wr_preset_s ? bus.dev_writeData      : preset_r;
      irq_s    = ctrl_s[3] && (state_s == ST_INT);
   end

   // State and register file flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         ctrl_r   <= 4'd0;
         preset_r <= 32'd0;
         count_r  <= 32'd0;
         irq_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         ctrl_r   <= ctrl_s;
         preset_r <= preset_s;
         count_r  <= count_s;
         irq_r    <= irq_s;
      end
   end

   // Combinational read mux, zero-padded
   always_comb begin
      case (bus.dev_addr)
         2'd0:    rd_s = {28'd0, ctrl_r};
         2'd1:    rd_s = preset_r;
         2'd2:    rd_s = count_r;
         default: rd_s = 32'd0;
      endcase
   end

   assign bus.timer_rd = rd_s;
   assign bus.irq      = irq_r;

endmodule

// File: tb/tb_timer_dev.sv
// Directed testbench for timer_dev with hand-computed expected values.
module tb_timer_dev;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   timer_dev_if bus();

   timer_dev u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.dev_addr      = a;
      bus.dev_writeData = d;
      bus.we            = 1'b1;
      @(negedge clk);
      bus.we            = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.dev_addr = a;
      #1;
      check_val(tag, bus.timer_rd, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.dev_addr = 2'd0;
      bus.we = 1'b0;
      bus.dev_writeData = 32'd0;

      // 1: reset values
      repeat (2) @(negedge clk);
      rd("rst_ctrl", 2'd0, 32'd0);
      rd("rst_count", 2'd2, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 4; a++) rd($sformatf("post_rst_a%0d", a), a[1:0], 32'd0);
      check_val("post_rst_irq", {31'd0, bus.irq}, 32'd0);

      // 2: one-shot, PRESET=5
      @(negedge clk);
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      repeat (2) @(negedge clk);
      bus.dev_addr = 2'd2;
      for (int k = 0; k < 6; k++) begin
         #1;
         check_val($sformatf("os_count%0d", k), bus.timer_rd, 32'd5 - k);
         check_val($sformatf("os_irq_lo%0d", k), {31'd0, bus.irq}, 32'd0);
         @(negedge clk);
      end
      #1;
      check_val("os_irq_rise", {31'd0, bus.irq}, 32'd1);
      rd("os_ctrl_cleared", 2'd0, 32'h8);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check_val("os_irq_hold", {31'd0, bus.irq}, 32'd1);
      end
      @(negedge clk);
      wr(2'd1, 32'd7);
      #1;
      check_val("os_irq_ack", {31'd0, bus.irq}, 32'd0);

      // 3: auto-reload, PRESET=3 -> period 6
      @(negedge clk);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         #1;
         check_val($sformatf("ar_irq_n%0d", k), {31'd0, bus.irq},
                   ((k >= 6) && (((k - 6) % 6) == 0)) ? 32'd1 : 32'd0);
      end
      wr(2'd0, 32'hA);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         check_val("ar_stop_irq", {31'd0, bus.irq}, 32'd0);
      end
      rd("ar_frozen_count", 2'd2, 32'd3);

      // 4: PRESET change during countdown
      @(negedge clk);
      wr(2'd1, 32'd10);
      wr(2'd0, 32'hB);
      repeat (2) @(negedge clk);
      rd("pc_count10", 2'd2, 32'd10);
      wr(2'd1, 32'd2);
      rd("pc_count9", 2'd2, 32'd9);
      for (int k = 4; k <= 20; k++) begin
         @(negedge clk);
         #1;
         check_val($sformatf("pc_irq_n%0d", k), {31'd0, bus.irq},
                   ((k == 13) || (k == 18)) ? 32'd1 : 32'd0);
         if (k == 12) check_val("pc_count0", bus.timer_rd, 32'd0);
         if (k == 15) check_val("pc_reload2", bus.timer_rd, 32'd2);
      end
      @(negedge clk);
      wr(2'd0, 32'h0);
      repeat (3) @(negedge clk);

      // 5: reset mid-count
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h9);
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      for (int a = 0; a < 4; a++) rd($sformatf("mid_rst_a%0d", a), a[1:0], 32'd0);
      check_val("mid_rst_irq", {31'd0, bus.irq}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      rd("after_rst_count", 2'd2, 32'd0);
      rd("after_rst_ctrl", 2'd0, 32'd0);
      check_val("after_rst_irq", {31'd0, bus.irq}, 32'd0);

      // 6: PRESET=0, IM=0
      @(negedge clk);
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      repeat (2) @(negedge clk);
      rd("z_ctrl_en", 2'd0, 32'h1);
      check_val("z_irq_e2", {31'd0, bus.irq}, 32'd0);
      @(negedge clk);
      rd("z_ctrl_cleared", 2'd0, 32'h0);
      rd("z_count", 2'd2, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check_val("z_irq_masked", {31'd0, bus.irq}, 32'd0);
      end
      @(negedge clk);
      wr(2'd2, 32'h55);
      rd("z_count_ro", 2'd2, 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd("z_addr3", 2'd3, 32'd0);
      rd("z_ctrl_keep", 2'd0, 32'h0);
      rd("z_preset_keep", 2'd1, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped 32-bit down-counting timer on the CPU device bus.
- Sits directly downstream of the address-decode bridge, in the 0x00007Fxx window.
- Consumes the bridge's two-bit register select, timer write-enable and write data.
- Returns read data to the bridge and raises an interrupt request to the CPU.

Parameters:
- None. All register widths are fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- dev_addr  input  2  register select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  write strobe; already qualified by the bridge with CPU write and timer hit.
- dev_writeData  input  32  write data.
- timer_rd  output  32  read data, combinational from dev_addr.
- irq  output  1  interrupt request.

Behaviour:
- Registers:
  - CTRL holds bits [3:0]: [0]=EN, [2:1]=MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), [3]=IM (interrupt mask/enable). Bits [31:4] read 0.
  - PRESET is a 32-bit read/write register.
  - COUNT is a 32-bit read-only register; writes to it are ignored.
  - Address 3 reads 0; writes to it are ignored.
- Write: when we=1 at a clock edge, the register selected by dev_addr is loaded from dev_writeData.
- Read: timer_rd = register[dev_addr], zero-padded. No read side effects.
- Reset (rst_n=0, immediate): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq=0, timer_rd reflects the zeroed registers. Reset mid-count abandons the count with no irq.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - EN=0: go to IDLE; COUNT holds its value.
    - EN=1 and COUNT!=0: COUNT<=COUNT-1; stay in CNT.
    - EN=1 and COUNT==0: go to INT. If MODE!=01, clear EN at the same edge.
  - INT, MODE 01: stays exactly 1 cycle. Next state is LOAD if EN=1, else IDLE.
  - INT, other MODE: stays in INT until any write to CTRL or PRESET, then goes to IDLE.
- irq = IM & (state==INT). It is driven from flops only, so it is glitch-free.
- Latency:
  - EN write at edge e0 → LOAD at e1 → COUNT=P at e2 → COUNT=0 at e2+P → INT at e3+P.
  - irq first high in the cycle after edge e3+P.
  - Auto-reload period is P+3 cycles.
  - PRESET=0 gives INT at e3.
- Simultaneous events:
  - A CPU write to CTRL on the same edge as the EN auto-clear: the CPU value wins. The state still enters INT.
  - A PRESET write during CNT does not disturb COUNT. It takes effect at the next LOAD.
  - A CTRL write during CNT that sets EN=0 moves the FSM to IDLE on the following edge (COUNT frozen). Re-enabling later reloads from PRESET; it does not resume.
- Wrap-around: COUNT never decrements below 0. The COUNT==0 check precedes the decrement.
- IM=0: the FSM behaves identically, but irq stays 0.

Test Plan:
1. Reset, then read addresses 0..3 → all return 0x00000000; irq=0.
2. Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM):
   - COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD.
   - irq rises 8 cycles after the CTRL write edge and stays high.
   - CTRL reads 0x8.
   - A PRESET write then drops irq the next cycle.
3. PRESET=3, CTRL=0xB (auto-reload, IM) → irq is a 1-cycle pulse every 6 cycles for at least 4 periods. Then write CTRL=0xA → no further pulses; COUNT frozen.
4. During CNT with COUNT=10, write PRESET=2 → countdown continues from 10. The next reload starts from 2 (period 5).
5. Start a one-shot with PRESET=100, then assert rst_n=0 mid-count → all registers 0 immediately, irq=0. After release, nothing counts until EN is written.
6. PRESET=0, CTRL=0x1 (IM=0) → INT reached at e3; irq stays 0. CTRL reads 0x0. A write to address 2 (value 0x55) leaves COUNT unchanged.
